lif_config_sequencer: RTL

- Byte-stream command sequencer that configures and drives one LIF/PWM neuron pair.
- Parses opcode headers and stages multi-byte payloads, then commits each parameter atomically. The neuron never sees a half-loaded weight or input vector.
- RUN command asserts execute for a programmed number of cycles, counts returned spikes, then signals done.
- Sits between the top-level pin decoder and the neuron instances; replaces direct live shifting of config registers.

---
 rtl/lif_seq_pkg.sv | 31 +++
 rtl/lif_config_sequencer_sat_counter.sv | 24 ++
 rtl/lif_config_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lif_seq_pkg.sv
// Shared opcodes, FSM state encoding and reset constants for the LIF config sequencer.
package lif_seq_pkg;

    localparam logic [2:0] OP_INPUTS    = 3'b000;
    localparam logic [2:0] OP_WEIGHTS   = 3'b001;
    localparam logic [2:0] OP_THRESHOLD = 3'b010;
    localparam logic [2:0] OP_BIAS      = 3'b011;
    localparam logic [2:0] OP_SHIFT     = 3'b100;
    localparam logic [2:0] OP_RUN       = 3'b101;
    localparam logic [2:0] OP_BATCHNORM = 3'b110;
    localparam logic [2:0] OP_NOP       = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // WEIGHT_INIT is the fill bit replicated across the whole weight vector.
    localparam logic       WEIGHT_INIT    = 1'b1;
    localparam int         THRESHOLD_INIT = 5;
    localparam logic [7:0] BATCHNORM_INIT = 8'h04;

    function automatic int vec_bytes(input int n_stages);
        int n_inputs;
        n_inputs = 1 << n_stages;
        return (n_inputs / 8 < 1) ? 1 : n_inputs / 8;
    endfunction

endpackage

// File: rtl/lif_config_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the spike tally and payload timeout.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en && !(&r_count)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/lif_config_sequencer.sv
// Byte-stream command sequencer: stages payloads, commits neuron config atomically, runs RUN bursts.
// Optional payload idle timeout is built when LIF_SEQ_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a header byte
// PAYLOAD | collecting payload bytes for the latched opcode
// RUN     | execute asserted, counting returned spikes
// DONE    | one-cycle done pulse, tally final
module lif_config_sequencer
    import lif_seq_pkg::*;
#(
    parameter int N_STAGES     = 5,
    parameter int CNT_BITS     = 8,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2**N_STAGES-1:0] inputs_out,
    output logic [2**N_STAGES-1:0] weights_out,
    output logic [N_STAGES:0]      threshold_out,
    output logic [N_STAGES+1:0]    bias_out,
    output logic [2:0]             shift_out,
    output logic [7:0]             batchnorm_out,
    output logic                   execute,
    input  logic                   spike_in,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_BITS-1:0]    spike_count,
    output logic                   err
);

    localparam int INPUTS    = 2**N_STAGES;
    localparam int VEC_BYTES = vec_bytes(N_STAGES);
    localparam int STG_W     = VEC_BYTES * 8;
    localparam int TH_W      = N_STAGES + 1;
    localparam int BI_W      = N_STAGES + 2;
    localparam int BC_W      = $clog2(VEC_BYTES) + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_opcode;
    logic [STG_W-1:0]    r_stage;
    logic [BC_W-1:0]     r_byte_cnt;
    logic [CNT_BITS-1:0] r_run_cnt;
    logic [INPUTS-1:0]   r_inputs;
    logic [INPUTS-1:0]   r_weights;
    logic [TH_W-1:0]     r_threshold;
    logic [BI_W-1:0]     r_bias;
    logic [2:0]          r_shift;
    logic [7:0]          r_batchnorm;

    logic [STG_W-1:0]    w_stage_next;
    logic [CNT_BITS-1:0] w_run_n;
    logic                w_hdr_accept;
    logic                w_pay_accept;
    logic                w_last;
    logic                w_run_start;
    logic                w_timeout;

    // First byte ends up most significant once the vector is full.
    assign w_stage_next = STG_W'({r_stage, in_data});
    assign w_run_n      = CNT_BITS'(in_data);
    assign w_hdr_accept = (r_state == ST_IDLE) && in_valid;
    assign w_pay_accept = (r_state == ST_PAYLOAD) && in_valid;
    assign w_last       = (r_opcode == OP_INPUTS || r_opcode == OP_WEIGHTS)
                        ? (r_byte_cnt == BC_W'(VEC_BYTES - 1)) : 1'b1;
    assign w_run_start  = w_pay_accept && w_last && (r_opcode == OP_RUN);

    sat_counter #(.WIDTH(CNT_BITS)) u_spike_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_run_start),
        .i_en    ((r_state == ST_RUN) && spike_in),
        .o_count (spike_count)
    );

`ifdef LIF_SEQ_TIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] w_idle_cnt;

    sat_counter #(.WIDTH(TIMEOUT_BITS)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .i_clear ((r_state != ST_PAYLOAD) || in_valid),
        .i_en    ((r_state == ST_PAYLOAD) && !in_valid),
        .o_count (w_idle_cnt)
    );

    assign w_timeout = (r_state == ST_PAYLOAD) && !in_valid && (&w_idle_cnt);
`else
    // Constant 0: no timeout hardware in this build.
    assign w_timeout = (TIMEOUT_BITS < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        execute      = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_data[7:5] != OP_NOP) begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_last) begin
                        if (r_opcode == OP_RUN) begin
                            w_state_next = (w_run_n == '0) ? ST_DONE : ST_RUN;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                end else if (w_timeout) begin
                    err          = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                execute = 1'b1;
                if (r_run_cnt == CNT_BITS'(1)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode    <= OP_NOP;
            r_stage     <= '0;
            r_byte_cnt  <= '0;
            r_run_cnt   <= '0;
            r_inputs    <= '0;
            r_weights   <= {INPUTS{WEIGHT_INIT}};
            r_threshold <= TH_W'(THRESHOLD_INIT);
            r_bias      <= '0;
            r_shift     <= '0;
            r_batchnorm <= BATCHNORM_INIT;
        end else begin
            if (w_hdr_accept) begin
                r_opcode   <= in_data[7:5];
                r_stage    <= '0;
                r_byte_cnt <= '0;
            end
            if (w_pay_accept) begin
                r_stage    <= w_stage_next;
                r_byte_cnt <= r_byte_cnt + BC_W'(1);
                if (w_last) begin
                    case (r_opcode)
                        OP_INPUTS:    r_inputs    <= w_stage_next[INPUTS-1:0];
                        OP_WEIGHTS:   r_weights   <= w_stage_next[INPUTS-1:0];
                        OP_THRESHOLD: r_threshold <= TH_W'(in_data);
                        OP_BIAS:      r_bias      <= BI_W'(in_data);
                        OP_SHIFT:     r_shift     <= 3'(in_data);
                        OP_BATCHNORM: r_batchnorm <= in_data;
                        OP_RUN:       r_run_cnt   <= w_run_n;
                        default:      ;
                    endcase
                end
            end
            if (r_state == ST_RUN) begin
                r_run_cnt <= r_run_cnt - CNT_BITS'(1);
            end
        end
    end

    assign inputs_out    = r_inputs;
    assign weights_out   = r_weights;
    assign threshold_out = r_threshold;
    assign bias_out      = r_bias;
    assign shift_out     = r_shift;
    assign batchnorm_out = r_batchnorm;

endmodule
